seg7_scan_driver: RTL and testbench

Downstream display stage for the up/down seven-segment counter. It captures each new 7-bit active-low segment pattern from the counter/decoder into a DIGITS-deep history of distinct values. It then time-multiplexes that history onto one shared set of segment lines with one-hot digit enables. A blanking interval at the start of every digit slot suppresses ghosting.

---
 rtl/seg7_scan_driver.sv | 73 +++++++
 tb/tb_seg7_scan_driver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Seven-segment scan driver: keeps a history of distinct segment patterns and
// time-multiplexes it onto shared segment lines with per-slot blanking.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1024,
    parameter int BLANK    = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [6:0]        seg_in,
    input  logic              seg_valid_i,
    output logic [6:0]        seg_o,
    output logic [DIGITS-1:0] dig_en_o,
    output logic              frame_o
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_MAX   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK);
    localparam logic [IW-1:0] I_MAX   = IW'(DIGITS - 1);

    logic [DIGITS-1:0][6:0] hist;
    logic [PW-1:0]          p;
    logic [IW-1:0]          idx;
    logic                   capture;
    logic                   blank;
    logic                   p_wrap;

    assign capture = seg_valid_i && (seg_in != hist[0]);
    assign blank   = (BLANK != 0) && (p < P_BLANK);
    assign p_wrap  = (p == P_MAX);

    // History shift: newest at index 0, duplicates of the newest are dropped
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            hist <= '1;
        end else if (capture) begin
            for (int k = 1; k < DIGITS; k++)
                hist[k] <= hist[k-1];
            hist[0] <= seg_in;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            p   <= '0;
            idx <= '0;
        end else if (p_wrap) begin
            p   <= '0;
            idx <= (idx == I_MAX) ? '0 : idx + 1'b1;
        end else begin
            p <= p + 1'b1;
        end
    end

    // Outputs are registered from pre-edge scan state and history
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            seg_o    <= 7'b1111111;
            dig_en_o <= '0;
            frame_o  <= 1'b0;
        end else begin
            if (blank) begin
                seg_o    <= 7'b1111111;
                dig_en_o <= '0;
            end else begin
                seg_o    <= hist[idx];
                dig_en_o <= DIGITS'(1) << idx;
            end
            frame_o <= p_wrap && (idx == I_MAX);
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a short scan (8 clocks/slot, 2 blanked).
module tb_seg7_scan_driver;
    localparam int DIGITS = 4, SCAN_DIV = 8, BLANK = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        seg_in = 7'b1111111;
    logic              seg_valid = 1'b0;
    logic [6:0]        seg_o;
    logic [DIGITS-1:0] dig_en;
    logic              frame;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .seg_in      (seg_in),
        .seg_valid_i (seg_valid),
        .seg_o       (seg_o),
        .dig_en_o    (dig_en),
        .frame_o     (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Invariants checked every cycle while out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            assert ((dig_en & (dig_en - 1'b1)) == '0 && (dig_en != '0 || seg_o == 7'b1111111)) else begin
                n_fail++;
                $error("FAIL invariant observed dig_en=%b seg=%b expected onehot0/blank", dig_en, seg_o);
            end
        end
    end

    // One idle frame straight after reset release: everything blank, slots scan in order
    task automatic idle_frame_after_reset();
        for (int k = 1; k <= 32; k++) begin
            int ph, ix;
            tick();
            ph = (k - 1) % SCAN_DIV;
            ix = (k - 1) / SCAN_DIV;
            chk($sformatf("rst_dig_e%0d", k), 32'(dig_en), (ph >= BLANK) ? (32'd1 << ix) : 32'd0);
            chk($sformatf("rst_seg_e%0d", k), 32'(seg_o), 32'h7f);
            chk($sformatf("rst_frame_e%0d", k), 32'(frame), (k == 32) ? 32'd1 : 32'd0);
        end
    endtask

    // One full frame starting at a frame boundary, given the expected history
    task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] eb [4];
        eb[0] = e0; eb[1] = e1; eb[2] = e2; eb[3] = e3;
        for (int k = 1; k <= 32; k++) begin
            int ph, ix;
            tick();
            ph = (k - 1) % SCAN_DIV;
            ix = (k - 1) / SCAN_DIV;
            chk($sformatf("%s_dig_%0d", tag, k), 32'(dig_en), (ph >= BLANK) ? (32'd1 << ix) : 32'd0);
            chk($sformatf("%s_seg_%0d", tag, k), 32'(seg_o), (ph >= BLANK) ? 32'(eb[ix]) : 32'h7f);
            chk($sformatf("%s_frm_%0d", tag, k), 32'(frame), (k == 32) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        // Reset held, outputs at reset values
        #12;
        chk("reset_seg", 32'(seg_o), 32'h7f);
        chk("reset_dig", 32'(dig_en), 32'd0);
        chk("reset_frame", 32'(frame), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle_frame_after_reset();                 // edges 1..32

        // Capture four values on edges 33..36
        seg_valid = 1'b1;
        seg_in = 7'b0000001; tick();
        seg_in = 7'b1001111; tick();
        seg_in = 7'b0010010; tick();
        seg_in = 7'b0000110; tick();
        seg_valid = 1'b0;
        for (int i = 37; i <= 64; i++) tick();
        check_frame("cap", 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001);   // edges 65..96

        // Held value for 50 cycles: exactly one shift
        seg_valid = 1'b1;
        seg_in = 7'b1001100;
        for (int i = 97; i <= 146; i++) tick();
        seg_valid = 1'b0;
        for (int i = 147; i <= 160; i++) tick();
        check_frame("hold", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);  // edges 161..192

        // Capture during an active digit-0 slot
        for (int i = 193; i <= 195; i++) tick();
        chk("live_pre_seg", 32'(seg_o), 32'(7'b1001100));
        chk("live_pre_dig", 32'(dig_en), 32'd1);
        seg_valid = 1'b1;
        seg_in = 7'b0100100;
        tick();                                   // edge 196: strobe
        seg_valid = 1'b0;
        chk("live_strobe_seg", 32'(seg_o), 32'(7'b1001100));
        chk("live_strobe_dig", 32'(dig_en), 32'd1);
        tick();                                   // edge 197
        chk("live_new_seg", 32'(seg_o), 32'(7'b0100100));
        chk("live_new_dig", 32'(dig_en), 32'd1);
        tick();                                   // edge 198
        chk("live_hold_seg", 32'(seg_o), 32'(7'b0100100));

        // Asynchronous reset between edges, mid-slot
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_seg", 32'(seg_o), 32'h7f);
        chk("async_rst_dig", 32'(dig_en), 32'd0);
        chk("async_rst_frame", 32'(frame), 32'd0);
        tick();
        tick();
        chk("in_rst_seg", 32'(seg_o), 32'h7f);
        rst_n = 1'b1;
        idle_frame_after_reset();                 // restart and history blank

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
